// File: rtl/redirect_flush_ctrl_if.sv
// Redirect handshake between the flush controller (master) and the fetch unit (slave).
interface redirect_flush_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [1:0]      cause;

    modport master (output valid, output pc, output cause, input ready);
    modport slave  (input valid, input pc, input cause, output ready);
endinterface

// File: rtl/redirect_flush_ctrl.sv
// Redirect / flush controller: picks the highest-priority MEM-stage control-flow event,
// presents one PC redirect to fetch, holds it while fetch stalls, and then masks the
// wrong-path fetch responses that were already in flight when the redirect was taken.
module redirect_flush_ctrl #(
    parameter int XLEN          = 32,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_trap_i,
    input  logic [XLEN-1:0]       mem_trap_pc_i,
    input  logic                  mem_is_mret_i,
    input  logic [XLEN-1:0]       mem_mepc_i,
    input  logic                  mem_is_sret_i,
    input  logic [XLEN-1:0]       mem_sepc_i,
    input  logic                  mem_br_jmp_i,
    input  logic [XLEN-1:0]       mem_br_tgt_i,
    redirect_flush_ctrl_if.master redir,
    output logic                  flush_o,
    output logic                  drop_fetch_o,
    output logic [31:0]           redir_count_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    localparam logic [3:0] SQ_INIT = 4'(SQUASH_CYCLES);

    state_t            state_r;
    state_t            next_state_s;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   next_pc_s;
    logic [1:0]        cause_r;
    logic [1:0]        next_cause_s;
    logic [3:0]        sq_cnt_r;
    logic [3:0]        next_sq_s;
    logic [31:0]       count_r;
    logic [31:0]       next_count_s;

    logic              ev_any_s;
    logic [XLEN-1:0]   win_pc_s;
    logic [1:0]        win_cause_s;
    logic              valid_s;
    logic              flush_s;
    logic              drop_s;

    assign ev_any_s = mem_trap_i | mem_is_mret_i | mem_is_sret_i | mem_br_jmp_i;

    // Fixed-priority winner among simultaneous events: trap > mret > sret > branch/jump.
    always_comb begin
        win_pc_s    = mem_br_tgt_i;
        win_cause_s = 2'd0;
        if (mem_trap_i) begin
            win_pc_s    = mem_trap_pc_i;
            win_cause_s = 2'd3;
        end else if (mem_is_mret_i) begin
            win_pc_s    = mem_mepc_i;
            win_cause_s = 2'd2;
        end else if (mem_is_sret_i) begin
            win_pc_s    = mem_sepc_i;
            win_cause_s = 2'd1;
        end else begin
            win_pc_s    = mem_br_tgt_i;
            win_cause_s = 2'd0;
        end
    end

    // Next-state and output decode; a late trap while pending overrides the stored redirect.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        next_cause_s = cause_r;
        next_sq_s    = sq_cnt_r;
        next_count_s = count_r;
        valid_s      = 1'b0;
        flush_s      = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                flush_s = ev_any_s;
                if (ev_any_s) begin
                    next_pc_s    = win_pc_s;
                    next_cause_s = win_cause_s;
                    next_state_s = PEND;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PEND: begin
                valid_s = 1'b1;
                flush_s = 1'b1;
                if (mem_trap_i) begin
                    // Trap outranks whatever is pending; no handshake counted this cycle.
                    next_pc_s    = mem_trap_pc_i;
                    next_cause_s = 2'd3;
                    next_state_s = PEND;
                end else if (redir.ready) begin
                    next_count_s = count_r + 32'd1;
                    next_sq_s    = SQ_INIT;
                    next_state_s = SQUASH;
                end else begin
                    next_state_s = PEND;
                end
            end
            SQUASH: begin
                drop_s = 1'b1;
                if (ev_any_s) begin
                    // New event aborts the drop window and starts a fresh redirect.
                    flush_s      = 1'b1;
                    next_pc_s    = win_pc_s;
                    next_cause_s = win_cause_s;
                    next_sq_s    = 4'd0;
                    next_state_s = PEND;
                end else if (sq_cnt_r <= 4'd1) begin
                    next_sq_s    = 4'd0;
                    next_state_s = IDLE;
                end else begin
                    next_sq_s    = sq_cnt_r - 4'd1;
                    next_state_s = SQUASH;
                end
            end
            default: begin
                next_sq_s    = 4'd0;
                next_state_s = IDLE;
            end
        endcase
    end

    // State, latched redirect, squash window and acceptance counter; reset overrides events.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            pc_r     <= '0;
            cause_r  <= 2'd0;
            sq_cnt_r <= 4'd0;
            count_r  <= 32'd0;
        end else begin
            state_r  <= next_state_s;
            pc_r     <= next_pc_s;
            cause_r  <= next_cause_s;
            sq_cnt_r <= next_sq_s;
            count_r  <= next_count_s;
        end
    end

    assign redir.valid   = valid_s;
    assign redir.pc      = pc_r;
    assign redir.cause   = cause_r;
    assign flush_o       = flush_s;
    assign drop_fetch_o  = drop_s;
    assign redir_count_o = count_r;

endmodule

// File: tb/tb_redirect_flush_ctrl.sv
// Scoreboard bench for redirect_flush_ctrl: directed scenarios followed by random traffic.
module tb_redirect_flush_ctrl;

    localparam int SQ = 2;

    typedef struct {
        logic        valid;
        logic        flush;
        logic        drop;
        logic [31:0] pc;
        logic [1:0]  cause;
        logic [31:0] count;
    } cyc_t;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  cause;
        logic [31:0] count;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap, mret, sret, br;
    logic [31:0] trap_pc, mepc, sepc, br_tgt;
    logic        flush, drop;
    logic [31:0] count;

    redirect_flush_ctrl_if #(.XLEN(32)) rif ();

    redirect_flush_ctrl #(.XLEN(32), .SQUASH_CYCLES(SQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_trap_i    (trap),
        .mem_trap_pc_i (trap_pc),
        .mem_is_mret_i (mret),
        .mem_mepc_i    (mepc),
        .mem_is_sret_i (sret),
        .mem_sepc_i    (sepc),
        .mem_br_jmp_i  (br),
        .mem_br_tgt_i  (br_tgt),
        .redir         (rif.master),
        .flush_o       (flush),
        .drop_fetch_o  (drop),
        .redir_count_o (count)
    );

    always #5 clk = ~clk;

    // staged stimulus, applied on the next falling edge
    logic        s_rst, s_trap, s_mret, s_sret, s_br, s_rdy;
    logic [31:0] s_trap_pc, s_mepc, s_sepc, s_br_tgt;

    // reference model: is a redirect outstanding, where to, how many drops remain
    bit          m_pending;
    logic [31:0] m_pc;
    logic [1:0]  m_cause;
    int          m_drop_left;
    logic [31:0] m_count;

    cyc_t cyc_q[$];
    acc_t acc_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        s_rst = 1'b0; s_trap = 1'b0; s_mret = 1'b0; s_sret = 1'b0; s_br = 1'b0;
    endtask

    // One clock cycle: apply stimulus, predict this cycle's outputs, advance the model.
    task automatic step();
        cyc_t        e;
        acc_t        a;
        logic        ev;
        logic [31:0] wpc;
        logic [1:0]  wc;
        @(negedge clk);
        rst = s_rst; trap = s_trap; mret = s_mret; sret = s_sret; br = s_br;
        trap_pc = s_trap_pc; mepc = s_mepc; sepc = s_sepc; br_tgt = s_br_tgt;
        rif.ready = s_rdy;
        ev = s_trap | s_mret | s_sret | s_br;
        e.valid = m_pending;
        e.flush = m_pending | ev;
        e.drop  = (m_drop_left > 0);
        e.pc    = m_pc;
        e.cause = m_cause;
        e.count = m_count;
        cyc_q.push_back(e);
        if (s_trap)      begin wpc = s_trap_pc; wc = 2'd3; end
        else if (s_mret) begin wpc = s_mepc;    wc = 2'd2; end
        else if (s_sret) begin wpc = s_sepc;    wc = 2'd1; end
        else             begin wpc = s_br_tgt;  wc = 2'd0; end
        if (m_pending && !s_trap && s_rdy) begin
            a.pc = m_pc; a.cause = m_cause; a.count = m_count;
            acc_q.push_back(a);
        end
        if (s_rst) begin
            m_pending = 1'b0; m_drop_left = 0; m_count = 32'd0;
            m_pc = 32'd0; m_cause = 2'd0;
        end else if (m_pending) begin
            if (s_trap) begin
                m_pc = s_trap_pc; m_cause = 2'd3;
            end else if (s_rdy) begin
                m_pending = 1'b0; m_drop_left = SQ; m_count = m_count + 32'd1;
            end
        end else if (ev) begin
            m_pending = 1'b1; m_pc = wpc; m_cause = wc; m_drop_left = 0;
        end else if (m_drop_left > 0) begin
            m_drop_left--;
        end
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: per-cycle outputs, plus the handshake record whenever fetch accepts.
    initial begin
        cyc_t e;
        acc_t a;
        forever begin
            @(negedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("valid", 32'(rif.valid), 32'(e.valid));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("drop", 32'(drop), 32'(e.drop));
                chk("count", count, e.count);
                if (e.valid) begin
                    chk("pc", rif.pc, e.pc);
                    chk("cause", 32'(rif.cause), 32'(e.cause));
                end
                if (rif.valid === 1'b1 && rif.ready === 1'b1 && trap === 1'b0) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_accept", 32'd1, 32'd0);
                    end else begin
                        a = acc_q.pop_front();
                        chk("acc_pc", rif.pc, a.pc);
                        chk("acc_cause", 32'(rif.cause), 32'(a.cause));
                        chk("acc_count", count, a.count);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; trap = 1'b0; mret = 1'b0; sret = 1'b0; br = 1'b0;
        trap_pc = 32'd0; mepc = 32'd0; sepc = 32'd0; br_tgt = 32'd0; rif.ready = 1'b0;
        m_pending = 1'b0; m_pc = 32'd0; m_cause = 2'd0; m_drop_left = 0; m_count = 32'd0;
        s_trap_pc = 32'd0; s_mepc = 32'd0; s_sepc = 32'd0; s_br_tgt = 32'd0; s_rdy = 1'b0;
        clr();
        s_rst = 1'b1;
        repeat (2) @(posedge clk);
        step(); step();
        // 1: branch, fetch always ready
        s_rdy = 1'b1; s_br = 1'b1; s_br_tgt = 32'h8000_0040; step();
        idle(5);
        // 2: simultaneous trap, mret, branch -> trap wins
        s_trap = 1'b1; s_trap_pc = 32'h8000_0100; s_mret = 1'b1; s_mepc = 32'h8000_0200;
        s_br = 1'b1; s_br_tgt = 32'h8000_0300; step();
        idle(5);
        // 3: sret with fetch stalled five cycles
        s_rdy = 1'b0; s_sret = 1'b1; s_sepc = 32'h8000_1000; step();
        idle(5);
        s_rdy = 1'b1; idle(5);
        // 4: branch, then branch and trap while pending
        s_rdy = 1'b0; s_br = 1'b1; s_br_tgt = 32'h8000_0500; step();
        s_br_tgt = 32'h8000_0600; step();
        clr(); s_trap = 1'b1; s_trap_pc = 32'h8000_0004; step();
        idle(1);
        s_rdy = 1'b1; idle(5);
        // 5: mret in the first squash cycle
        s_br = 1'b1; s_br_tgt = 32'h8000_0700; step();
        idle(1);
        s_mret = 1'b1; s_mepc = 32'h8000_0800; step();
        idle(6);
        // 6: reset while a redirect is pending
        s_rdy = 1'b0; s_br = 1'b1; s_br_tgt = 32'h8000_0900; step();
        idle(1);
        s_rst = 1'b1; step();
        idle(3);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s_rst     = ($urandom_range(0, 299) == 0);
            s_trap    = ($urandom_range(0, 15) == 0);
            s_mret    = ($urandom_range(0, 11) == 0);
            s_sret    = ($urandom_range(0, 11) == 0);
            s_br      = ($urandom_range(0, 4) == 0);
            s_rdy     = ($urandom_range(0, 3) != 0);
            s_trap_pc = $urandom & 32'hFFFF_FFFC;
            s_mepc    = $urandom & 32'hFFFF_FFFC;
            s_sepc    = $urandom & 32'hFFFF_FFFC;
            s_br_tgt  = $urandom & 32'hFFFF_FFFC;
            step();
        end
        s_rdy = 1'b1;
        idle(8);
        @(negedge clk);
        #2;
        chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
